segment_descriptor_fetch: RTL and testbench
===========================================

Name: segment_descriptor_fetch

Overview:
- Upstream stage of the segment descriptor decoder.
- On a segment-register load, it takes a 16-bit selector and picks GDT or LDT by selector TI. It checks the selector index against the table limit, then reads the 8-byte descriptor as two 32-bit memory reads.
- It presents the assembled 64-bit descriptor, in the layout the decoder consumes, on a valid/ready response port, together with null-selector and fault status.

Parameters:
- WAIT_LIMIT, 255, maximum cycles to wait for mem_read_ack per read before a timeout fault; 0 disables the timeout.
- WAIT_COUNTER_WIDTH, 8, width of the wait counter; must satisfy WAIT_LIMIT < 2**WAIT_COUNTER_WIDTH.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request_valid  in  1  selector load request.
- request_ready  out  1  high only in IDLE.
- request_selector  in  16  [15:3] index, [2] TI (0=GDT, 1=LDT), [1:0] RPL.
- gdtr_base  in  32  GDT linear base.
- gdtr_limit  in  16  GDT byte limit.
- ldtr_base  in  32  LDT linear base.
- ldtr_limit  in  16  LDT byte limit.
- mem_read_request  out  1  read strobe, held until ack.
- mem_address  out  32  linear address of the dword being read.
- mem_read_ack  in  1  read data valid this cycle.
- mem_read_error  in  1  bus error; sampled with mem_read_ack.
- mem_read_data  in  32  returned dword.
- response_valid  out  1  result available.
- response_ready  in  1  consumer accepts result.
- response_descriptor  out  64  {dword@addr, dword@addr+4}; zero on null selector or fault.
- response_null_selector  out  1  TI=0 and index=0.
- response_fault  out  1  result is a fault.
- response_fault_cause  out  2  0 none, 1 limit, 2 bus error, 3 timeout.
- response_error_code  out  16  {selector[15:2], 2'b00} on fault, else 0.

Behaviour:
- Reset: clock and reset are as stated under Already decided. With reset_n low, all of the following are forced immediately, independent of clock:
  - FSM in IDLE.
  - request_ready=1; every other output 0.
  - wait counter 0.
- A reset mid-operation abandons any outstanding read. No response is produced for the abandoned request.
- States: IDLE, READ_LOW, READ_HIGH, RESPOND.
- IDLE: on request_valid && request_ready, capture the selector, the selected base and the selected limit. The table inputs are not re-sampled afterwards.
  - Null selector: go to RESPOND with null_selector=1 and a zero descriptor. No memory access.
  - Limit fault: if {index,3'b111} > limit (17-bit compare), go to RESPOND with fault, cause 1. No memory access.
  - Otherwise: go to READ_LOW.
- TI=1 with index 0 is not null; it is an ordinary LDT access.
- READ_LOW:
  - Drive mem_read_request=1 and mem_address = base + {index,3'b000}, wrapping modulo 2^32.
  - On ack without error: store data in descriptor[63:32], go to READ_HIGH.
- READ_HIGH:
  - Drive mem_address = previous address + 4, wrapping modulo 2^32.
  - On ack without error: store data in descriptor[31:0], go to RESPOND.
- Errors in either read state:
  - ack with mem_read_error: fault, cause 2, descriptor cleared.
  - WAIT_LIMIT != 0 and WAIT_LIMIT cycles elapse without ack: fault, cause 3; mem_read_request drops.
  - The wait counter clears on entry to each read state.
- mem_read_request is registered. It drops in the cycle after ack.
- A mem_read_ack arriving in IDLE or RESPOND is ignored.
- RESPOND: response_valid=1 and all response_* outputs held stable until response_ready. On acceptance go to IDLE and clear the response outputs.
- Back-pressure: request_ready stays 0 until the response is accepted; one request is in flight at a time.
- Latency, request accept to response_valid, with zero-wait memory (ack the cycle after request):
  - 1 cycle for null or limit-fault.
  - 5 cycles for a normal fetch.

Decomposition:
- Shared package segmentation_pkg holds:
  - the state enum;
  - fault cause constants FAULT_NONE, FAULT_LIMIT, FAULT_BUS, FAULT_TIMEOUT;
  - a selector struct (index, table_indicator, rpl).
- No sub-module; the address/limit check is inline logic. The output feeds segment_descriptor_decode unchanged.

Test Plan:
- Normal GDT fetch: gdtr_base=0x0001_0000, gdtr_limit=0x00FF, selector=0x0010. Requires:
  - reads at 0x0001_0010 then 0x0001_0014;
  - data 0x1234_FFFF then 0x00CF_9A00 gives descriptor 0x1234_FFFF_00CF_9A00, fault=0.
- Null and LDT: selector=0x0003 gives null_selector=1 with no mem_read_request ever asserted. selector=0x0004 with ldtr_base=0x2000 and ldtr_limit=0x0007 reads 0x2000 and 0x2004.
- Limit boundary: gdtr_limit=0x0017. selector 0x0010 passes. selector 0x0018 gives fault cause 1, error_code 0x0018, no memory access. selector 0x001B gives error_code 0x0018.
- Bus error and timeout:
  - mem_read_error with the second ack gives cause 2 and descriptor 0.
  - WAIT_LIMIT=4 with no ack gives cause 3 exactly 4 cycles after mem_read_request rises.
- Back-pressure, wrap and reset:
  - response_ready held low 10 cycles: outputs stable, request_ready=0.
  - base 0xFFFF_FFF8, selector 0x0008: reads 0x0000_0000 then 0x0000_0004.
  - reset_n pulsed low during READ_HIGH: immediate IDLE, all outputs 0, no response.

Source files
------------

// File: rtl/segmentation_pkg.sv
// Shared types for the segment descriptor fetch/decode pipeline: fetch FSM
// states, fault cause codes and the selector layout.
package segmentation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_LOW  = 2'd1,
    ST_READ_HIGH = 2'd2,
    ST_RESPOND   = 2'd3
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_LIMIT   = 2'd1;
  localparam logic [1:0] FAULT_BUS     = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [12:0] index;
    logic        table_indicator;
    logic [1:0]  rpl;
  } selector_t;

  // A GDT selector with index 0 is the null selector; LDT index 0 is a real entry.
  function automatic logic is_null_selector(input logic [12:0] index, input logic table_indicator);
    return (index == 13'd0) && !table_indicator;
  endfunction

endpackage

// File: rtl/segment_descriptor_fetch.sv
// Fetches an 8-byte segment descriptor from the GDT or LDT for a selector load,
// with limit checking, bus-error and timeout faults, and a valid/ready response.
module segment_descriptor_fetch
  import segmentation_pkg::*;
#(
  parameter int WAIT_LIMIT         = 255,
  parameter int WAIT_COUNTER_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [15:0] request_selector,
  input  logic [31:0] gdtr_base,
  input  logic [15:0] gdtr_limit,
  input  logic [31:0] ldtr_base,
  input  logic [15:0] ldtr_limit,
  output logic        mem_read_request,
  output logic [31:0] mem_address,
  input  logic        mem_read_ack,
  input  logic        mem_read_error,
  input  logic [31:0] mem_read_data,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [63:0] response_descriptor,
  output logic        response_null_selector,
  output logic        response_fault,
  output logic [1:0]  response_fault_cause,
  output logic [15:0] response_error_code
);

  fetch_state_e                  state;
  logic [WAIT_COUNTER_WIDTH-1:0] wait_count;
  logic [31:0]                   low_dword;
  logic [15:0]                   error_code_q;

  selector_t   sel_in;
  logic [31:0] table_base;
  logic [15:0] table_limit;
  logic        limit_violation;
  logic        wait_expired;
  logic        selector_rpl_unused;

  assign sel_in      = selector_t'(request_selector);
  assign table_base  = sel_in.table_indicator ? ldtr_base  : gdtr_base;
  assign table_limit = sel_in.table_indicator ? ldtr_limit : gdtr_limit;

  // The last byte of the 8-byte entry must lie inside the table's byte limit.
  assign limit_violation = {1'b0, sel_in.index, 3'b111} > {1'b0, table_limit};

  // RPL plays no part in locating or checking the descriptor.
  assign selector_rpl_unused = ^sel_in.rpl;

  generate
    if (WAIT_LIMIT != 0) begin : g_timeout
      assign wait_expired = (wait_count == WAIT_COUNTER_WIDTH'(WAIT_LIMIT - 1));
    end else begin : g_no_timeout
      assign wait_expired = 1'b0;
    end
  endgenerate

  // NOTE: handshake flags decode the state register directly, so request_ready
  // is already 1 while reset_n is held low, with no clock edge required.
  assign request_ready  = (state == ST_IDLE);
  assign response_valid = (state == ST_RESPOND);

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; mixing in = would make results order-dependent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= ST_IDLE;
      wait_count             <= '0;
      low_dword              <= '0;
      error_code_q           <= '0;
      mem_read_request       <= 1'b0;
      mem_address            <= '0;
      response_descriptor    <= '0;
      response_null_selector <= 1'b0;
      response_fault         <= 1'b0;
      response_fault_cause   <= FAULT_NONE;
      response_error_code    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request_valid) begin
            wait_count   <= '0;
            error_code_q <= {sel_in.index, sel_in.table_indicator, 2'b00};
            if (is_null_selector(sel_in.index, sel_in.table_indicator)) begin
              response_null_selector <= 1'b1;
              state                  <= ST_RESPOND;
            end else if (limit_violation) begin
              response_fault       <= 1'b1;
              response_fault_cause <= FAULT_LIMIT;
              response_error_code  <= {sel_in.index, sel_in.table_indicator, 2'b00};
              state                <= ST_RESPOND;
            end else begin
              mem_read_request <= 1'b1;
              mem_address      <= table_base + {16'd0, sel_in.index, 3'b000};
              state            <= ST_READ_LOW;
            end
          end
        end

        ST_READ_LOW, ST_READ_HIGH: begin
          if (mem_read_ack) begin
            wait_count <= '0;
            if (mem_read_error) begin
              mem_read_request     <= 1'b0;
              response_fault       <= 1'b1;
              response_fault_cause <= FAULT_BUS;
              response_error_code  <= error_code_q;
              state                <= ST_RESPOND;
            end else if (state == ST_READ_LOW) begin
              // The request stays up: the high dword read starts immediately.
              low_dword   <= mem_read_data;
              mem_address <= mem_address + 32'd4;
              state       <= ST_READ_HIGH;
            end else begin
              mem_read_request    <= 1'b0;
              response_descriptor <= {low_dword, mem_read_data};
              state               <= ST_RESPOND;
            end
          end else if (wait_expired) begin
            mem_read_request     <= 1'b0;
            response_fault       <= 1'b1;
            response_fault_cause <= FAULT_TIMEOUT;
            response_error_code  <= error_code_q;
            state                <= ST_RESPOND;
          end else begin
            wait_count <= wait_count + WAIT_COUNTER_WIDTH'(1);
          end
        end

        ST_RESPOND: begin
          if (response_ready) begin
            response_descriptor    <= '0;
            response_null_selector <= 1'b0;
            response_fault         <= 1'b0;
            response_fault_cause   <= FAULT_NONE;
            response_error_code    <= '0;
            state                  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_descriptor_fetch.sv
// Self-checking bench for segment_descriptor_fetch: directed cases plus randomized
// fetches against a table/memory reference model with a reactive memory responder.
module tb_segment_descriptor_fetch;

  localparam int WAIT_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        request_valid = 1'b0;
  logic        request_ready;
  logic [15:0] request_selector = '0;
  logic [31:0] gdtr_base = '0;
  logic [15:0] gdtr_limit = '0;
  logic [31:0] ldtr_base = '0;
  logic [15:0] ldtr_limit = '0;
  logic        mem_read_request;
  logic [31:0] mem_address;
  logic        mem_read_ack = 1'b0;
  logic        mem_read_error = 1'b0;
  logic [31:0] mem_read_data = '0;
  logic        response_valid;
  logic        response_ready = 1'b0;
  logic [63:0] response_descriptor;
  logic        response_null_selector;
  logic        response_fault;
  logic [1:0]  response_fault_cause;
  logic [15:0] response_error_code;

  segment_descriptor_fetch #(.WAIT_LIMIT(WAIT_LIMIT), .WAIT_COUNTER_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_selector(request_selector),
    .gdtr_base(gdtr_base), .gdtr_limit(gdtr_limit),
    .ldtr_base(ldtr_base), .ldtr_limit(ldtr_limit),
    .mem_read_request(mem_read_request), .mem_address(mem_address),
    .mem_read_ack(mem_read_ack), .mem_read_error(mem_read_error),
    .mem_read_data(mem_read_data),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_descriptor(response_descriptor),
    .response_null_selector(response_null_selector),
    .response_fault(response_fault), .response_fault_cause(response_fault_cause),
    .response_error_code(response_error_code)
  );

  initial forever #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // ---------------- memory image and responder ----------------
  bit [31:0] mem_img [bit [31:0]];

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  int        mem_delay = 0;     // extra cycles before each ack
  int        mem_err_read = 0;  // 1-based read number that returns a bus error
  bit        mem_silent = 1'b0; // never acknowledge
  int        mem_acks = 0;
  int        mem_wait = 0;
  bit        mem_req_seen = 1'b0;
  bit [31:0] addr_log [$];

  // Acks one cycle after a read becomes visible (plus mem_delay), one-cycle pulses.
  initial forever begin
    @(posedge clock);
    #1;
    if (mem_read_request) mem_req_seen = 1'b1;
    if (mem_read_ack) begin
      mem_read_ack   = 1'b0;
      mem_read_error = 1'b0;
      mem_read_data  = '0;
      mem_wait       = mem_read_request ? 1 : 0;
    end else if (mem_read_request && !mem_silent) begin
      if (mem_wait >= 1 + mem_delay) begin
        mem_acks++;
        mem_read_ack   = 1'b1;
        mem_read_error = (mem_acks == mem_err_read);
        mem_read_data  = mem_word(mem_address);
        addr_log.push_back(mem_address);
        mem_wait = 0;
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit        null_sel;
    bit        fault;
    bit [1:0]  cause;
    bit [63:0] desc;
    bit [15:0] ecode;
    int        lat;
    int        nreads;
    bit [31:0] addr0;
    bit        touches_mem;
  } expect_t;

  function automatic expect_t predict(input bit [15:0] sel, input int d, input int err_read, input bit silent);
    expect_t     e;
    int unsigned idx;
    int unsigned limit;
    bit [31:0]   base;
    e = '{default: 0};
    idx   = int'(sel) >> 3;
    base  = sel[2] ? ldtr_base : gdtr_base;
    limit = sel[2] ? int'(ldtr_limit) : int'(gdtr_limit);
    if (!sel[2] && idx == 0) begin
      e.null_sel = 1'b1;
      e.lat      = 1;
    end else if (idx * 8 + 7 > limit) begin
      e.fault = 1'b1; e.cause = 2'd1; e.ecode = sel & 16'hFFFC; e.lat = 1;
    end else begin
      e.touches_mem = 1'b1;
      e.addr0 = base + 32'(idx * 8);
      if (silent) begin
        e.fault = 1'b1; e.cause = 2'd3; e.ecode = sel & 16'hFFFC; e.lat = 1 + WAIT_LIMIT;
      end else if (err_read == 1) begin
        e.fault = 1'b1; e.cause = 2'd2; e.ecode = sel & 16'hFFFC; e.lat = 3 + d; e.nreads = 1;
      end else begin
        e.nreads = 2;
        e.lat    = 5 + 2 * d;
        if (err_read == 2) begin
          e.fault = 1'b1; e.cause = 2'd2; e.ecode = sel & 16'hFFFC;
        end else begin
          e.desc = {mem_word(e.addr0), mem_word(e.addr0 + 32'd4)};
        end
      end
    end
    return e;
  endfunction

  // ---------------- one complete transaction ----------------
  task automatic run_txn(input string tag, input bit [15:0] sel, input int d, input int err_read,
                         input bit silent, input int hold_cycles);
    expect_t e;
    int      guard;
    int      lat;
    @(posedge clock); #2;
    guard = 0;
    while (!request_ready && guard < 20) begin
      @(posedge clock); #2; guard++;
    end
    check({tag, " request_ready idle"}, request_ready, 1'b1);
    e = predict(sel, d, err_read, silent);
    mem_delay = d; mem_err_read = err_read; mem_silent = silent;
    mem_acks = 0; mem_req_seen = 1'b0; addr_log.delete();
    request_valid = 1'b1; request_selector = sel;
    @(posedge clock); #2;
    request_valid = 1'b0; request_selector = 16'($urandom);
    // Tables change after acceptance; the captured values must be used.
    gdtr_base = $urandom; ldtr_base = $urandom;
    gdtr_limit = 16'($urandom); ldtr_limit = 16'($urandom);
    lat = 1;
    while (!response_valid && lat < 40) begin
      @(posedge clock); #2; lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(e.lat));
    check({tag, " valid"}, response_valid, 1'b1);
    check({tag, " descriptor"}, response_descriptor, e.desc);
    check({tag, " null/fault/cause"}, {response_null_selector, response_fault, response_fault_cause},
          {e.null_sel, e.fault, e.cause});
    check({tag, " error_code"}, response_error_code, e.ecode);
    check({tag, " req dropped, not ready"}, {mem_read_request, request_ready}, 2'b00);
    check({tag, " memory touched"}, mem_req_seen, e.touches_mem);
    check({tag, " read count"}, 64'(addr_log.size()), 64'(e.nreads));
    for (int i = 0; i < addr_log.size() && i < e.nreads; i++)
      check($sformatf("%s read%0d address", tag, i), addr_log[i], e.addr0 + 32'(4 * i));
    for (int c = 0; c < hold_cycles; c++) begin
      request_valid = 1'b1; request_selector = 16'($urandom);
      @(posedge clock); #2;
      check({tag, " hold valid/ready"}, {response_valid, request_ready}, 2'b10);
      check({tag, " hold outputs"},
            {response_descriptor[47:0], response_null_selector, response_fault,
             response_fault_cause, response_error_code[11:0]},
            {e.desc[47:0], e.null_sel, e.fault, e.cause, e.ecode[11:0]});
      check({tag, " hold desc top"}, {response_descriptor[63:48], response_error_code[15:12]},
            {e.desc[63:48], e.ecode[15:12]});
    end
    request_valid = 1'b0;
    response_ready = 1'b1;
    @(posedge clock); #2;
    response_ready = 1'b0;
    check({tag, " after accept"},
          {request_ready, response_valid, response_null_selector, response_fault,
           response_fault_cause, response_error_code},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0});
    check({tag, " after accept desc"}, response_descriptor, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " flags"},
          {request_ready, mem_read_request, response_valid, response_null_selector, response_fault},
          5'b10000);
    check({tag, " address"}, mem_address, 32'd0);
    check({tag, " descriptor"}, response_descriptor, 64'd0);
    check({tag, " cause/code"}, {response_fault_cause, response_error_code}, 18'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          guard;
    bit          saw;
    bit [15:0]   sel;
    int          r;
    #3;
    check_reset_outputs("reset");
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b1;

    // Normal GDT fetch, zero-wait memory, then 10 cycles of back-pressure.
    gdtr_base = 32'h0001_0000; gdtr_limit = 16'h00FF;
    mem_img[32'h0001_0010] = 32'h1234_FFFF;
    mem_img[32'h0001_0014] = 32'h00CF_9A00;
    run_txn("gdt", 16'h0010, 0, 0, 1'b0, 10);
    check("gdt literal descriptor", {mem_img[32'h0001_0010], mem_img[32'h0001_0014]} ^ response_descriptor,
          64'h1234_FFFF_00CF_9A00);

    // Null selector and LDT index 0.
    gdtr_base = 32'h0001_0000; gdtr_limit = 16'h00FF;
    run_txn("null", 16'h0003, 0, 0, 1'b0, 0);
    ldtr_base = 32'h0000_2000; ldtr_limit = 16'h0007;
    run_txn("ldt0", 16'h0004, 0, 0, 1'b0, 0);

    // Limit boundary.
    gdtr_base = 32'h0004_0000; gdtr_limit = 16'h0017;
    run_txn("lim pass", 16'h0010, 0, 0, 1'b0, 0);
    gdtr_base = 32'h0004_0000; gdtr_limit = 16'h0017;
    run_txn("lim fault", 16'h0018, 0, 0, 1'b0, 0);
    gdtr_base = 32'h0004_0000; gdtr_limit = 16'h0017;
    run_txn("lim rpl", 16'h001B, 0, 0, 1'b0, 0);

    // Bus error on the second ack, and timeout with no ack.
    gdtr_base = 32'h0005_0000; gdtr_limit = 16'h00FF;
    run_txn("bus err", 16'h0020, 0, 2, 1'b0, 0);
    gdtr_base = 32'h0005_0000; gdtr_limit = 16'h00FF;
    run_txn("timeout", 16'h0028, 0, 0, 1'b1, 0);

    // Address wrap.
    gdtr_base = 32'hFFFF_FFF8; gdtr_limit = 16'h00FF;
    run_txn("wrap", 16'h0008, 0, 0, 1'b0, 0);

    // Reset during READ_HIGH.
    gdtr_base = 32'h0000_3000; gdtr_limit = 16'h00FF;
    mem_delay = 1; mem_silent = 1'b0; mem_err_read = 0; mem_acks = 0;
    @(posedge clock); #2;
    request_valid = 1'b1; request_selector = 16'h0010;
    @(posedge clock); #2;
    request_valid = 1'b0;
    guard = 0;
    while (!(mem_read_request && mem_address == 32'h0000_3014) && guard < 20) begin
      @(posedge clock); #2; guard++;
    end
    check("rst_mid reached high read", 64'(guard < 20), 64'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    #2 reset_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clock); #2;
      if (response_valid || mem_read_request) saw = 1'b1;
    end
    check("rst_mid no response", saw, 1'b0);
    check("rst_mid ready", request_ready, 1'b1);

    // Randomized fetches.
    for (int t = 0; t < 40; t++) begin
      gdtr_base  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : $urandom;
      ldtr_base  = $urandom;
      gdtr_limit = 16'($urandom_range(0, 16'h0180));
      ldtr_limit = 16'($urandom_range(0, 16'h0180)) | 16'h0007;
      sel = {13'($urandom_range(0, 40)), 1'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) sel[15:3] = '0;
      r = $urandom_range(0, 9);
      run_txn($sformatf("rand%0d", t), sel, $urandom_range(0, 1),
              (r == 0) ? 1 : (r == 1) ? 2 : 0, (r == 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
